seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
Parametrised, multi-cycle shift/rotate unit for the ALU datapath. It supersedes the fixed 32-bit combinational arithmetic-right shifter. It supports five operations: logical right, arithmetic right, logical left, rotate right and rotate left. It processes up to STEP bit positions per clock under a start/done handshake, which keeps the shifter off the critical path and frees the ALU controller while a shift is in flight.

Parameters:
WIDTH, 32, data width in bits; must be a power of two, at least 8.
SHAMT_W, 5, shift-amount field width; must equal log2(WIDTH).
STEP, 1, maximum bit positions shifted per cycle; must be a power of two, between 1 and WIDTH/2.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
clr  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only when ready=1.
op  input  3  000 shr, 001 shra, 010 shl, 011 ror, 100 rol; 101-111 illegal.
in  input  WIDTH  operand.
num_shifts  input  32  shift amount; only bits [SHAMT_W-1:0] are used.
out  output  WIDTH  registered result; held until the next accepted start.
ready  output  1  high in IDLE.
busy  output  1  high in LOAD-accepted SHIFT and DONE states (busy = ~ready).
done  output  1  one-cycle pulse when out becomes valid.
err  output  1  registered; set with done when op was illegal, cleared on the next accepted start.

Behaviour:
- Reset: clr=1 asynchronously forces the following, regardless of clk:
  - state=IDLE;
  - out=0, done=0, err=0;
  - internal working register=0, count=0, latched op=0.
  - ready=1 while clr is high. Reset mid-shift abandons the operation; no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1, latch op, load work=in, and load cnt=num_shifts[SHAMT_W-1:0]. The amount is taken modulo WIDTH; upper bits are ignored silently.
  - If cnt==0 or op is illegal: set out=in, set err=(op illegal), and go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, each edge:
  - k = min(cnt, STEP); apply k-bit op to work; cnt -= k.
  - If the new cnt==0: out = shifted value, go to DONE. Otherwise stay in SHIFT.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. out and err hold.
- start while busy (SHIFT or DONE) is ignored; it is not queued. Inputs in, op and num_shifts may change freely after acceptance.
- Latency: start accepted at edge k gives done high during the cycle after edge k + ceil(s/STEP), where s is the masked amount. For s=0 that is the cycle after edge k.
- Shift semantics per step of k bits:
  - shr: zero fill from the MSB side.
  - shra: MSB replicated into the k vacated upper bits.
  - shl: zero fill from the LSB side.
  - ror: bits leaving the LSB re-enter at the MSB.
  - rol: bits leaving the MSB re-enter at the LSB.
- Composition: results equal the single combinational shift by s. Rotation by s is the exact mod-WIDTH rotation; shr/shl by s<WIDTH never saturate.
- done is never asserted in the same cycle as ready=1.
- A start arriving in the same cycle that done is high is ignored, because state≠IDLE. The earliest next acceptance is the following cycle.

Test Plan:
- Reset and idle: assert clr mid-cycle → out=0, done=0, ready=1 immediately, with no clock edge needed.
- shra, STEP=1: op=001, in=0x80000010, num_shifts=4 → done after 4 cycles, out=0xF8000001. Same operands with op=000 → out=0x08000001.
- Rotates, STEP=4:
  - op=011, in=0x0000000F, num_shifts=4 → done after 1 cycle, out=0xF0000000.
  - op=100, in=0x80000001, num_shifts=9 → done after 3 cycles, out=0x00000300.
- Boundaries:
  - op=010, in=1, num_shifts=31 (STEP=1) → done after 31 cycles, out=0x80000000.
  - num_shifts=35 → behaves as 3.
  - num_shifts=0, in=0x1234ABCD → done next cycle, out=0x1234ABCD.
- Handshake:
  - Pulse start with s=8, then pulse start again at cycle 3 with different in → ignored; first result delivered.
  - Assert clr at cycle 5 → no done; ready=1; out=0.
- Illegal op: op=110, in=0xDEADBEEF, num_shifts=7 → done next cycle, out=0xDEADBEEF, err=1. A following legal op clears err.

Source files
------------

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate unit with a start/done handshake.
// Each clock shifts the working value by up to STEP bit positions.
// Supported ops are shr, shra, shl, ror and rol. Codes 101-111 are illegal.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-high reset
//   start      request pulse; accepted only while ready=1
//   op         3'd0 shr, 3'd1 shra, 3'd2 shl, 3'd3 ror, 3'd4 rol
//   in         operand
//   num_shifts shift amount; only [SHAMT_W-1:0] is used (mod WIDTH)
//   out        registered result; held until the next accepted start
//   ready      high in IDLE
//   busy       ~ready
//   done       one-cycle pulse when out becomes valid
//   err        registered; set with done for an illegal op
//
// Parameter rules: WIDTH is a power of two and at least 8.
// SHAMT_W = log2(WIDTH). STEP is a power of two in [1, WIDTH/2].
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic [31:0]      num_shifts,
  output logic [WIDTH-1:0] out,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   work, work_nxt;
  logic [SHAMT_W-1:0] cnt, cnt_nxt, k, amt;
  logic [2:0]         op_q;
  logic               illegal, short_path;

  // Upper amount bits are dropped on purpose (amount is mod WIDTH).
  logic unused_hi;
  assign unused_hi = ^num_shifts[31:SHAMT_W];

  // k-bit step of the latched op.
  // Rotates use (-k mod WIDTH) for the wrap-around half.
  // k is never 0 here because SHIFT is only entered with cnt > 0.
  function automatic logic [WIDTH-1:0] step_shift(
    input logic [2:0]         o,
    input logic [WIDTH-1:0]   v,
    input logic [SHAMT_W-1:0] sh
  );
    logic [SHAMT_W-1:0] rk;
    rk = SHAMT_W'(0) - sh;
    case (o)
      3'd0:    step_shift = v >> sh;
      3'd1:    step_shift = $unsigned($signed(v) >>> sh);
      3'd2:    step_shift = v << sh;
      3'd3:    step_shift = (v >> sh) | (v << rk);
      3'd4:    step_shift = (v << sh) | (v >> rk);
      default: step_shift = v;
    endcase
  endfunction

  assign amt        = num_shifts[SHAMT_W-1:0];
  assign illegal    = (op > 3'd4);
  assign short_path = (amt == '0) || illegal;
  assign k          = (cnt < STEP_C) ? cnt : STEP_C;
  assign cnt_nxt    = cnt - k;
  assign work_nxt   = step_shift(op_q, work, k);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = short_path ? DONE : SHIFT;
      end
      SHIFT: if (cnt_nxt == '0) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy = ~ready;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out  <= '0;
      err  <= 1'b0;
      work <= '0;
      cnt  <= '0;
      op_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q <= op;
          work <= in;
          cnt  <= amt;
          err  <= illegal;
          if (short_path) out <= in;
        end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt_nxt;
          if (cnt_nxt == '0) out <= work_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit.
// Two instances, STEP=1 and STEP=4, share one stimulus stream.
// Each instance has its own expectation queue and monitor.
module tb_seq_shift_unit;

  logic        clk, clr, start;
  logic [2:0]  op;
  logic [31:0] din, ns;
  logic [31:0] out1, out4;
  logic        rdy1, rdy4, bsy1, bsy4, dn1, dn4, er1, er4;

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u1 (
    .clk(clk), .clr(clr), .start(start), .op(op), .in(din), .num_shifts(ns),
    .out(out1), .ready(rdy1), .busy(bsy1), .done(dn1), .err(er1));

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u4 (
    .clk(clk), .clr(clr), .start(start), .op(op), .in(din), .num_shifts(ns),
    .out(out4), .ready(rdy4), .busy(bsy4), .done(dn4), .err(er4));

  typedef struct {
    logic [31:0] o;
    logic        e;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t        q1[$], q4[$];
  int          checks = 0, errors = 0, cyc = 0;
  logic [31:0] last1 = '0, last4 = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: the whole shift done in one go, on a widened operand.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] n,
                       output logic [31:0] r, output logic e);
    int                 s;
    logic        [63:0] d;
    logic signed [63:0] sx;
    s = int'(n % 32);
    e = 1'b0;
    case (o)
      3'd0: r = a >> s;
      3'd1: begin sx = {{32{a[31]}}, a}; sx = sx >>> s; r = sx[31:0]; end
      3'd2: r = a << s;
      3'd3: begin d = {a, a} >> s; r = d[31:0]; end
      3'd4: begin d = {a, a} << s; r = d[63:32]; end
      default: begin r = a; e = 1'b1; end
    endcase
  endtask

  // Monitors: on every done, pop and compare value, err and latency.
  always @(negedge clk) begin
    exp_t x;
    if (dn1) begin
      chk("u1 ready_with_done", {31'b0, rdy1}, 32'd0);
      if (q1.size() == 0) chk("u1 unexpected_done", 32'd1, 32'd0);
      else begin
        x = q1.pop_front();
        chk("u1 out", out1, x.o);
        chk("u1 err", {31'b0, er1}, {31'b0, x.e});
        chk("u1 latency", cyc - x.cyc, x.lat);
        last1 = x.o;
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (dn4) begin
      chk("u4 ready_with_done", {31'b0, rdy4}, 32'd0);
      if (q4.size() == 0) chk("u4 unexpected_done", 32'd1, 32'd0);
      else begin
        x = q4.pop_front();
        chk("u4 out", out4, x.o);
        chk("u4 err", {31'b0, er4}, {31'b0, x.e});
        chk("u4 latency", cyc - x.cyc, x.lat);
        last4 = x.o;
      end
    end
  end

  // Wait at negedges until both units are idle, then check that out held.
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(rdy1 && rdy4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
    chk("u1 out_hold", out1, last1);
    chk("u4 out_hold", out4, last4);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] n,
                       input logic [31:0] eo, input logic ee);
    int   s;
    exp_t x;
    wait_idle();
    op    = o;
    din   = a;
    ns    = n;
    start = 1'b1;
    s     = ee ? 0 : int'(n % 32);
    x.o   = eo;
    x.e   = ee;
    x.cyc = cyc;
    x.lat = 1 + s;
    q1.push_back(x);
    x.lat = 1 + (s + 3) / 4;
    q4.push_back(x);
    @(negedge clk);
    start = 1'b0;
    // Operands may change freely once accepted.
    din = ~a;
    op  = 3'd7;
    ns  = $urandom;
  endtask

  task automatic issue_m(input logic [2:0] o, input logic [31:0] a, input logic [31:0] n);
    logic [31:0] r;
    logic        e;
    model(o, a, n, r, e);
    issue(o, a, n, r, e);
  endtask

  initial begin
    start = 1'b0;
    op    = '0;
    din   = '0;
    ns    = '0;
    clr   = 1'b1;
    #2;
    chk("reset u1 out", out1, 32'd0);
    chk("reset u4 out", out4, 32'd0);
    chk("reset ready", {30'b0, rdy1, rdy4}, 32'd3);
    chk("reset done", {30'b0, dn1, dn4}, 32'd0);
    chk("reset err", {30'b0, er1, er4}, 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // Directed cases with fixed expected results.
    issue(3'd1, 32'h8000_0010, 32'd4,  32'hF800_0001, 1'b0);
    issue(3'd0, 32'h8000_0010, 32'd4,  32'h0800_0001, 1'b0);
    issue(3'd3, 32'h0000_000F, 32'd4,  32'hF000_0000, 1'b0);
    issue(3'd4, 32'h8000_0001, 32'd9,  32'h0000_0300, 1'b0);
    issue(3'd2, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0);
    issue(3'd2, 32'h0000_0001, 32'd35, 32'h0000_0008, 1'b0);
    issue(3'd0, 32'h1234_ABCD, 32'd0,  32'h1234_ABCD, 1'b0);
    issue(3'd6, 32'hDEAD_BEEF, 32'd7,  32'hDEAD_BEEF, 1'b1);
    issue(3'd3, 32'hDEAD_BEEF, 32'd8,  32'hEFDE_ADBE, 1'b0);

    // A start while busy is ignored: first result still delivered.
    // An extra done would hit an empty queue.
    issue_m(3'd0, 32'hA5A5_0000, 32'd8);
    start = 1'b1;
    din   = 32'h1111_1111;
    op    = 3'd2;
    ns    = 32'd1;
    repeat (3) @(negedge clk);
    start = 1'b0;

    // clr mid-shift: state drops at once and no done ever appears.
    issue_m(3'd2, 32'h0000_00FF, 32'd8);
    repeat (3) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr u1 out", out1, 32'd0);
    chk("clr u4 out", out4, 32'd0);
    chk("clr ready", {30'b0, rdy1, rdy4}, 32'd3);
    chk("clr done", {30'b0, dn1, dn4}, 32'd0);
    chk("clr busy", {30'b0, bsy1, bsy4}, 32'd0);
    q1.delete();
    q4.delete();
    last1 = '0;
    last4 = '0;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_clr no_done u1", {31'b0, rdy1}, 32'd1);

    // Random traffic, mostly legal ops.
    for (int i = 0; i < 80; i++) begin
      logic [2:0] o;
      o = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      issue_m(o, $urandom, $urandom);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    chk("u1 queue_drained", q1.size(), 32'd0);
    chk("u4 queue_drained", q4.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
